// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: shares one byte-wide valid/ready output channel among eight
// requesters.
//
// A grant covers a burst of up to MAX_BURST beats. The burst ends early on the
// granted source's `last` marker. Between bursts there is always one idle
// cycle, and re-arbitration happens during that cycle.
//
// Build option:
//   MUX8_ARB_FIXED_PRIO_EN - when defined, the idle-state choice is fixed
//   priority (lowest index wins) and no round-robin pointer is kept. When
//   undefined (the default), arbitration is round-robin starting at source 0.

module mux8_rr_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  req,
    input  logic [7:0]  last,
    input  logic [63:0] d_in,
    output logic [7:0]  gnt,
    output logic [2:0]  sel,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        beat_ack
);

    localparam int unsigned CntW = $clog2(MAX_BURST) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      gnt_q, gnt_d;
    logic [2:0]      sel_q, sel_d;
    logic            valid_q, valid_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            any_req;
    logic [2:0]      winner;
    logic            ack;
    logic            burst_end;

    assign any_req = |req;
    assign ack     = valid_q & out_ready;

    // With MAX_BURST == 1, CntMax is 0 and cnt_q never leaves 0. Every beat
    // therefore ends the burst, whatever `last` says.
    assign burst_end = last[sel_q] | (cnt_q == CntMax);

`ifdef MUX8_ARB_FIXED_PRIO_EN

    // Fixed priority: lowest set request index wins.
    always_comb begin
        winner = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                winner = 3'(i);
            end
        end
    end

`else

    logic [2:0] last_gnt_q, last_gnt_d;
    logic [2:0] rr_idx;
    logic       rr_found;

    // Round-robin: scan last_gnt+1 .. last_gnt+8 (mod 8).
    // The source served last is therefore checked last.
    always_comb begin
        winner   = 3'd0;
        rr_idx   = 3'd0;
        rr_found = 1'b0;
        for (int unsigned k = 1; k <= 8; k++) begin
            rr_idx = last_gnt_q + 3'(k);
            if (!rr_found && req[rr_idx]) begin
                winner   = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    // Round-robin pointer. Reset to 7 so that source 0 is served first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt_q <= 3'd7;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    // Pointer advances to the source whose burst just completed.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (state_q == StBusy && ack && burst_end) begin
            last_gnt_d = sel_q;
        end
    end

`endif

    // State and registered outputs. Reset drops any grant immediately, and an
    // in-flight beat is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            gnt_q   <= 8'd0;
            sel_q   <= 3'd0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. Grant on any request in idle.
    // In busy, the grant is held until a handshake ends the burst.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StBusy;
                    gnt_d   = 8'd1 << winner;
                    sel_d   = winner;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            StBusy: begin
                // A request drop without a handshake is ignored; there is no
                // abort path.
                if (ack) begin
                    if (burst_end) begin
                        state_d = StIdle;
                        gnt_d   = 8'd0;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs: registered grant state plus the data mux driven by the
    // registered select.
    always_comb begin
        gnt       = gnt_q;
        sel       = sel_q;
        out_valid = valid_q;
        beat_ack  = ack;
        out_data  = d_in[{sel_q, 3'b000} +: 8];
    end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit output channel among eight byte-wide requesters.
- Owns the 3-bit select of an internal 8:1 byte multiplexer.
- Grants one requester at a time for a burst of up to MAX_BURST beats, then moves to the next requester.
- Sits between processor-side sources (register file ports, ALU result, I/O) and a single shared destination bus with a valid/ready handshake.

Parameters:
- MAX_BURST, 4: maximum beats per grant; legal range 1..16. Beat counter width is $clog2(MAX_BURST)+1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  8  request per source; bit i = source i.
- last  in  8  per-source end-of-burst marker; only sampled at a handshake of the granted source.
- d_in  in  64  packed source data; byte i = d_in[8i+7:8i].
- gnt  out  8  one-hot grant, registered; all-zero when idle.
- sel  out  3  registered select (index of granted source); holds its last value when idle.
- out_data  out  8  the selected byte of d_in; combinational from the registered sel.
- out_valid  out  1  registered; high exactly while a grant is active.
- out_ready  in  1  downstream accepts the beat.
- beat_ack  out  1  combinational; equals out_valid AND out_ready (a beat is transferred this cycle).

Behaviour:
- Reset (async, reset_n low):
  - gnt=0, sel=0, out_valid=0.
  - Round-robin pointer last_gnt=7, so source 0 has first priority.
  - Beat count=0, FSM=IDLE.
  - Reset asserted mid-burst drops the grant immediately; the in-flight beat is lost.
- FSM has two states: IDLE and BUSY.
- IDLE:
  - If any req bit is high, choose the first set bit searching last_gnt+1, last_gnt+2, … modulo 8.
  - Next edge: gnt=onehot(winner), sel=winner, out_valid=1, count=0, state=BUSY.
  - Grant latency is 1 cycle from req sampled high.
  - If req=0, stay in IDLE; all outputs hold.
- BUSY:
  - out_valid=1 and out_data=d_in[sel]. The granted source must hold its byte stable until beat_ack.
  - No beat_ack: hold everything. A drop of req[sel] is ignored; there is no abort without a handshake.
  - beat_ack and (last[sel]=1 or count==MAX_BURST-1): burst ends. Next edge: gnt=0, out_valid=0, last_gnt=sel, state=IDLE.
  - beat_ack otherwise: count increments and the grant holds.
- Every burst end costs one idle bubble cycle; re-arbitration happens in IDLE.
- out_valid never falls without a handshake, except on reset.
- Fairness: a source that has just been served is lowest priority in the next arbitration. With all eight requesting, grants rotate 0,1,…,7,0.
- MAX_BURST=1: every beat ends the burst, and last is ignored.
- req bits for non-granted sources may change at any time with no effect until the next IDLE.

Optional Feature:
- MUX8_ARB_FIXED_PRIO_EN.
- When defined: the IDLE choice is fixed priority, lowest index wins. last_gnt is not updated and need not be implemented.
- When not defined: round-robin as above.
- Burst, handshake and reset behaviour are identical in both modes.

Test Plan:
- Reset then req=8'h01, last=8'h01, d_in byte0=8'hA5, out_ready=1:
  - gnt=8'h01, sel=0, out_valid=1, out_data=8'hA5 one cycle after req.
  - beat_ack pulses once, then gnt=0 with IDLE for 1 cycle.
- req=8'hFF held, last=8'hFF, out_ready=1:
  - Grant sequence is 8'h01,02,04,…,80,01.
  - Each grant lasts 1 beat, followed by 1 idle cycle.
- req=8'h08, last=0, MAX_BURST=4, out_ready=1:
  - Source 3 is granted for exactly 4 beats (count 0..3), then released.
  - While req stays high: re-granted after 1 idle cycle.
- Granted source 2, out_ready=0 for 5 cycles, req[2] dropped in cycle 2:
  - out_valid, gnt=8'h04 and sel=2 stay stable and beat_ack=0 throughout.
  - Transfer occurs when out_ready rises.
- reset_n pulsed low mid-burst (source 5, count=2):
  - gnt=0, out_valid=0 and sel=0 immediately.
  - After release with req=8'hFF, the first grant is source 0.
- MUX8_ARB_FIXED_PRIO_EN defined, req=8'h24 held, last=8'hFF:
  - Source 2 is granted every time, source 5 is never granted.
  - After req becomes 8'h20, source 5 is granted.
